ysyx_23060111_core_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the ysyx_23060111 NPC core. It fetches instructions over a single shared valid/ready memory port and holds each one stable while the combinational ALU evaluates it. It then runs any load/store the ALU requests on the same port, and commits the register-file write and the next PC. It replaces the single-cycle "ideal memory" assumption, so instruction and data memory can have arbitrary latency.

---
 rtl/ysyx_23060111_pkg.sv | 35 +++
 rtl/ysyx_23060111_core_ctrl_if.sv | 23 ++
 rtl/ysyx_23060111_lane_align.sv | 25 ++
 rtl/ysyx_23060111_core_ctrl.sv | 148 ++++++++++++++
 tb/tb_ysyx_23060111_core_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060111_pkg.sv
// Shared types and constants for the ysyx_23060111 core sequencer.
// Macro YSYX_23060111_MISALIGN_TRAP_EN adds the HALT state for misaligned-access trapping.
package ysyx_23060111_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_IWAIT,
        ST_EXEC,
        ST_DREQ,
        ST_DWAIT,
        ST_COMMIT
`ifdef YSYX_23060111_MISALIGN_TRAP_EN
        , ST_HALT
`endif
    } state_t;

    // Any byte count other than 1 or 2 is treated as a full word.
    function automatic logic [2:0] size_enc(input logic [31:0] wmask);
        if (wmask == 32'd1)      return SZ_B;
        else if (wmask == 32'd2) return SZ_H;
        else                     return SZ_W;
    endfunction

    function automatic logic misaligned(input logic [31:0] addr, input logic [2:0] size);
        return ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_23060111_core_ctrl_if.sv
// Shared valid/ready memory port: one request channel, one response pulse.
interface ysyx_23060111_core_ctrl_if;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/ysyx_23060111_lane_align.sv
// Byte-lane alignment between right-aligned ALU data and the word-wide memory bus.
module ysyx_23060111_lane_align
    import ysyx_23060111_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] st_data,
    output logic [31:0] st_lane,
    output logic [3:0]  st_strb,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [3:0] base_strb;

    // Shift store data/strobes up to the byte offset, load data down from it.
    always_comb begin
        base_strb = (size == SZ_B) ? 4'b0001 :
                    (size == SZ_H) ? 4'b0011 : 4'b1111;
        st_strb   = base_strb << off;
        st_lane   = st_data << {off, 3'b000};
        ld_data   = ld_word >> {off, 3'b000};
    end

endmodule

// File: rtl/ysyx_23060111_core_ctrl.sv
// Multi-cycle fetch / execute / memory / commit sequencer over one shared memory port.
// Macro YSYX_23060111_MISALIGN_TRAP_EN enables the sticky misalignment halt.
module ysyx_23060111_core_ctrl
    import ysyx_23060111_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060111_core_ctrl_if.master  mem,
    output logic [31:0]                pc,
    output logic [31:0]                snpc,
    output logic [31:0]                inst,
    input  logic                       alu_m_ren,
    input  logic [31:0]                alu_m_raddr,
    input  logic                       alu_m_wen,
    input  logic [31:0]                alu_m_waddr,
    input  logic [31:0]                alu_m_wdata,
    input  logic [31:0]                alu_m_wmask,
    output logic [31:0]                alu_m_rdata,
    input  logic                       alu_wen,
    input  logic [31:0]                alu_dnpc,
    output logic                       rf_wen,
    output logic                       commit,
    output logic                       halt
);

    state_t      state, state_nxt;
    logic [31:0] pc_q, inst_q, ld_q;
    logic [31:0] m_addr_q, m_wdata_q;
    logic        m_store_q;
    logic [2:0]  m_size_q;

    logic        acc;
    logic [31:0] acc_addr;
    logic [31:0] st_lane, ld_shifted;
    logic [3:0]  st_strb;

    assign acc      = alu_m_ren | alu_m_wen;
    assign acc_addr = alu_m_ren ? alu_m_raddr : alu_m_waddr;

`ifdef YSYX_23060111_MISALIGN_TRAP_EN
    logic trap;
    logic halt_q;
    assign trap = (acc && misaligned(acc_addr, size_enc(alu_m_wmask))) || (alu_dnpc[1:0] != 2'b00);
    assign halt = halt_q;
`else
    assign halt = 1'b0;
`endif

    ysyx_23060111_lane_align u_lane (
        .off     (m_addr_q[1:0]),
        .size    (m_size_q),
        .st_data (m_wdata_q),
        .st_lane (st_lane),
        .st_strb (st_strb),
        .ld_word (mem.mem_resp_rdata),
        .ld_data (ld_shifted)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nxt;
    end

    // Next-state decode and memory-port / commit outputs.
    always_comb begin
        state_nxt         = state;
        mem.mem_req_valid = 1'b0;
        mem.mem_req_addr  = {m_addr_q[31:2], 2'b00};
        mem.mem_req_wen   = 1'b0;
        mem.mem_req_wdata = '0;
        mem.mem_req_wstrb = '0;
        rf_wen            = 1'b0;
        commit            = 1'b0;
        case (state)
            ST_FETCH: begin
                mem.mem_req_valid = ~rst;
                mem.mem_req_addr  = pc_q;
                if (mem.mem_req_ready) state_nxt = ST_IWAIT;
            end
            ST_IWAIT: if (mem.mem_resp_valid) state_nxt = ST_EXEC;
            ST_EXEC: begin
`ifdef YSYX_23060111_MISALIGN_TRAP_EN
                if (trap)     state_nxt = ST_HALT;
                else
`endif
                if (acc)      state_nxt = ST_DREQ;
                else          state_nxt = ST_COMMIT;
            end
            ST_DREQ: begin
                mem.mem_req_valid = ~rst;
                mem.mem_req_wen   = m_store_q;
                mem.mem_req_wdata = m_store_q ? st_lane : '0;
                mem.mem_req_wstrb = m_store_q ? st_strb : '0;
                if (mem.mem_req_ready) state_nxt = ST_DWAIT;
            end
            ST_DWAIT: if (mem.mem_resp_valid) state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                rf_wen    = alu_wen;
                commit    = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = state;
        endcase
    end

    // Datapath registers: PC, instruction, latched memory request, load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            ld_q      <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_store_q <= 1'b0;
            m_size_q  <= '0;
`ifdef YSYX_23060111_MISALIGN_TRAP_EN
            halt_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IWAIT: if (mem.mem_resp_valid) inst_q <= mem.mem_resp_rdata;
                ST_EXEC: begin
                    if (acc) begin
                        m_addr_q  <= acc_addr;
                        m_store_q <= ~alu_m_ren;
                        m_wdata_q <= alu_m_wdata;
                        m_size_q  <= size_enc(alu_m_wmask);
                    end
`ifdef YSYX_23060111_MISALIGN_TRAP_EN
                    if (trap) halt_q <= 1'b1;
`endif
                end
                ST_DWAIT:  if (mem.mem_resp_valid && !m_store_q) ld_q <= ld_shifted;
                ST_COMMIT: pc_q <= alu_dnpc;
                default: ;
            endcase
        end
    end

    assign pc          = pc_q;
    assign snpc        = pc_q + 32'd4;
    assign inst        = inst_q;
    assign alu_m_rdata = ld_q;

endmodule

// File: tb/tb_ysyx_23060111_core_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random instructions.
module tb_ysyx_23060111_core_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_23060111_core_ctrl_if mem_bus();

    logic [31:0] pc, snpc, inst, alu_m_rdata;
    logic        alu_m_ren, alu_m_wen, alu_wen, rf_wen, commit, halt;
    logic [31:0] alu_m_raddr, alu_m_waddr, alu_m_wdata, alu_m_wmask, alu_dnpc;

    ysyx_23060111_core_ctrl #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .mem(mem_bus),
        .pc(pc), .snpc(snpc), .inst(inst),
        .alu_m_ren(alu_m_ren), .alu_m_raddr(alu_m_raddr),
        .alu_m_wen(alu_m_wen), .alu_m_waddr(alu_m_waddr), .alu_m_wdata(alu_m_wdata),
        .alu_m_wmask(alu_m_wmask), .alu_m_rdata(alu_m_rdata),
        .alu_wen(alu_wen), .alu_dnpc(alu_dnpc),
        .rf_wen(rf_wen), .commit(commit), .halt(halt)
    );

    typedef struct {
        logic [31:0] inst;
        logic        ren, wen;
        logic [31:0] raddr, waddr, wdata, wmask, rdata;
        logic        alu_wen;
        logic [31:0] dnpc;
        int          fdly, rdly;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
    } vec_t;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic [31:0] exp_pc;
    vec_t        tbl[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic ren, input logic wen,
                                input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [31:0] wm, input logic [31:0] rd, input logic aw,
                                input logic [31:0] dn, input int fd, input int rdl,
                                input logic [31:0] ea, input logic [3:0] es,
                                input logic [31:0] ew, input logic [31:0] el);
        vec_t v;
        v.inst = i; v.ren = ren; v.wen = wen; v.raddr = ra; v.waddr = wa; v.wdata = wd;
        v.wmask = wm; v.rdata = rd; v.alu_wen = aw; v.dnpc = dn; v.fdly = fd; v.rdly = rdl;
        v.e_addr = ea; v.e_wstrb = es; v.e_wdata = ew; v.e_ld = el;
        return v;
    endfunction

    // Reference: a byte-granular view of the access, computed arithmetically.
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        logic [31:0] a = v.ren ? v.raddr : v.waddr;
        int          off = int'(a % 4);
        int          nbytes = (v.wmask == 1) ? 1 : (v.wmask == 2) ? 2 : 4;
        r.e_addr  = a - 32'(off);
        r.e_wstrb = '0;
        r.e_wdata = '0;
        r.e_ld    = '0;
        if (v.ren) begin
            r.e_ld = v.rdata / (32'd1 << (8 * off));
        end else if (v.wen) begin
            r.e_wstrb = 4'((((1 << nbytes) - 1) << off) % 16);
            r.e_wdata = 32'(64'(v.wdata) * (64'd1 << (8 * off)));
        end
        return r;
    endfunction

    task automatic set_alu(input vec_t v);
        alu_m_ren = v.ren; alu_m_raddr = v.raddr;
        alu_m_wen = v.wen; alu_m_waddr = v.waddr; alu_m_wdata = v.wdata;
        alu_m_wmask = v.wmask; alu_wen = v.alu_wen; alu_dnpc = v.dnpc;
    endtask

    task automatic wait_valid(output bit ok);
        #1;
        for (int i = 0; i < 20 && mem_bus.mem_req_valid !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        ok = (mem_bus.mem_req_valid === 1'b1);
        if (!ok) timeout("req_valid_wait");
    endtask

    task automatic wait_commit(output bit ok);
        #1;
        for (int i = 0; i < 20 && commit !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        ok = (commit === 1'b1);
        if (!ok) timeout("commit_wait");
    endtask

    // Hold ready low for dly cycles, handshake, then respond on the following cycle.
    task automatic handshake(input int dly, input logic [31:0] rd);
        logic [31:0] a0 = mem_bus.mem_req_addr;
        logic [31:0] d0 = mem_bus.mem_req_wdata;
        logic [3:0]  s0 = mem_bus.mem_req_wstrb;
        logic        w0 = mem_bus.mem_req_wen;
        for (int i = 0; i < dly; i++) begin
            mem_bus.mem_req_ready = 1'b0;
            @(negedge clk);
            #1;
            chk("hold_valid", 32'(mem_bus.mem_req_valid), 32'd1);
            chk("hold_addr", mem_bus.mem_req_addr, a0);
            chk("hold_wen", 32'(mem_bus.mem_req_wen), 32'(w0));
            chk("hold_wstrb", 32'(mem_bus.mem_req_wstrb), 32'(s0));
            chk("hold_wdata", mem_bus.mem_req_wdata, d0);
            chk("hold_no_commit", 32'(commit), 32'd0);
        end
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = rd;
        @(negedge clk);
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = $urandom;
    endtask

    task automatic run_vec(input vec_t v);
        bit          ok;
        int unsigned c0;
        set_alu(v);
        wait_valid(ok);
        if (!ok) return;
        c0 = cyc;
        chk("fetch_addr", mem_bus.mem_req_addr, exp_pc);
        chk("fetch_wen", 32'(mem_bus.mem_req_wen), 32'd0);
        handshake(v.fdly, v.inst);
        #1;
        chk("exec_inst", inst, v.inst);
        chk("exec_no_req", 32'(mem_bus.mem_req_valid), 32'd0);
        if (v.ren || v.wen) begin
            @(negedge clk);
            wait_valid(ok);
            if (!ok) return;
            chk("data_addr", mem_bus.mem_req_addr, v.e_addr);
            chk("data_wen", 32'(mem_bus.mem_req_wen), v.ren ? 32'd0 : 32'd1);
            chk("data_wstrb", 32'(mem_bus.mem_req_wstrb), 32'(v.e_wstrb));
            if (!v.ren) chk("data_wdata", mem_bus.mem_req_wdata, v.e_wdata);
            chk("data_inst_stable", inst, v.inst);
            handshake(v.rdly, v.rdata);
        end
        wait_commit(ok);
        if (!ok) return;
        chk("commit_rf_wen", 32'(rf_wen), 32'(v.alu_wen));
        if (v.ren) chk("commit_load_data", alu_m_rdata, v.e_ld);
        chk("commit_inst", inst, v.inst);
        chk("commit_pc", pc, exp_pc);
        chk("commit_snpc", snpc, exp_pc + 32'd4);
        if (v.fdly == 0 && v.rdly == 0)
            chk("commit_latency", cyc - c0 + 1, (v.ren || v.wen) ? 32'd6 : 32'd4);
        @(negedge clk);
        #1;
        chk("next_pc", pc, v.dnpc);
        chk("commit_one_cycle", 32'(commit), 32'd0);
        exp_pc = v.dnpc;
    endtask

    initial begin
        vec_t v;
        bit   ok;
        logic [31:0] r;
        int unsigned sizes[3] = '{1, 2, 4};

        // inst, ren, wen, raddr, waddr, wdata, wmask, rdata, alu_wen, dnpc, fdly, rdly, e_addr, e_wstrb, e_wdata, e_ld
        tbl.push_back(mk(32'h0010_0093, 0, 0, 0, 0, 0, 4, 0, 1, 32'h8000_0004, 0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(32'h00B0_01A3, 0, 1, 0, 32'h8000_1003, 32'h0000_00AB, 1, 0, 0, 32'h8000_0008, 0, 0,
                         32'h8000_1000, 4'b1000, 32'hAB00_0000, 0));
        tbl.push_back(mk(32'h0020_1103, 1, 0, 32'h8000_1002, 0, 0, 2, 32'hBEEF_1234, 1, 32'h8000_000C, 0, 0,
                         32'h8000_1000, 4'b0000, 0, 32'h0000_BEEF));
        tbl.push_back(mk(32'h00A0_2023, 0, 1, 0, 32'h8000_2000, 32'h1234_5678, 4, 0, 0, 32'h8000_0010, 0, 5,
                         32'h8000_2000, 4'b1111, 32'h1234_5678, 0));
        tbl.push_back(mk(32'h00A0_1123, 0, 1, 0, 32'h8000_2002, 32'h0000_CAFE, 2, 0, 0, 32'h8000_0100, 1, 2,
                         32'h8000_2000, 4'b1100, 32'hCAFE_0000, 0));
        tbl.push_back(mk(32'h0010_4083, 1, 1, 32'h8000_3001, 32'h8000_4000, 32'hFFFF_FFFF, 1, 32'h1122_3344, 1,
                         32'h8000_0104, 3, 0, 32'h8000_3000, 4'b0000, 0, 32'h0011_2233));
        tbl.push_back(mk(32'h0040_2083, 1, 0, 32'h8000_3004, 0, 0, 4, 32'hDEAD_BEEF, 1, 32'h8000_0108, 0, 0,
                         32'h8000_3004, 4'b0000, 0, 32'hDEAD_BEEF));
        tbl.push_back(mk(32'h0000_0013, 0, 0, 0, 0, 0, 4, 0, 1, 32'h8000_010C, 0, 0, 0, 4'b0000, 0, 0));
`ifndef YSYX_23060111_MISALIGN_TRAP_EN
        tbl.push_back(mk(32'h00A0_2023, 0, 1, 0, 32'h8000_5003, 32'hAABB_CCDD, 4, 0, 0, 32'h8000_0110, 0, 0,
                         32'h8000_5000, 4'b1000, 32'hDD00_0000, 0));
        tbl.push_back(mk(32'h0010_2083, 1, 0, 32'h8000_1001, 0, 0, 4, 32'h4433_2211, 1, 32'h8000_0114, 0, 0,
                         32'h8000_1000, 4'b0000, 0, 32'h0044_3322));
`endif

        rst = 1'b1;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = '0;
        set_alu(tbl[0]);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(mem_bus.mem_req_valid), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_snpc", snpc, RST_PC + 32'd4);
        chk("rst_inst", inst, 32'd0);
        chk("rst_load_reg", alu_m_rdata, 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        rst = 1'b0;
        exp_pc = RST_PC;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset while a load sits in DWAIT; the late response must be ignored.
        v = mk(32'h0000_2083, 1, 0, 32'h8000_3000, 0, 0, 4, 32'h5555_AAAA, 1, exp_pc + 32'd4, 0, 0,
               32'h8000_3000, 4'b0000, 0, 32'h5555_AAAA);
        set_alu(v);
        wait_valid(ok);
        handshake(0, v.inst);
        @(negedge clk);
        wait_valid(ok);
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_pc", pc, RST_PC);
        chk("abort_commit", 32'(commit), 32'd0);
        rst = 1'b0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = 32'h5555_AAAA;
        #1;
        chk("abort_fetch_valid", 32'(mem_bus.mem_req_valid), 32'd1);
        chk("abort_fetch_addr", mem_bus.mem_req_addr, RST_PC);
        @(negedge clk);
        mem_bus.mem_resp_valid = 1'b0;
        #1;
        chk("late_resp_inst", inst, 32'd0);
        chk("late_resp_load_reg", alu_m_rdata, 32'd0);
        chk("late_resp_still_fetch", 32'(mem_bus.mem_req_valid), 32'd1);
        chk("late_resp_no_commit", 32'(commit), 32'd0);
        exp_pc = RST_PC;
        run_vec(tbl[0]);

`ifdef YSYX_23060111_MISALIGN_TRAP_EN
        // Misaligned word load traps into the sticky halt.
        v = mk(32'h0010_2083, 1, 0, 32'h8000_1001, 0, 0, 4, 0, 1, exp_pc + 32'd4, 0, 0, 0, 4'b0000, 0, 0);
        set_alu(v);
        wait_valid(ok);
        handshake(0, v.inst);
        @(negedge clk);
        #1;
        chk("halt_set", 32'(halt), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("halt_no_req", 32'(mem_bus.mem_req_valid), 32'd0);
            chk("halt_no_commit", 32'(commit), 32'd0);
            chk("halt_sticky", 32'(halt), 32'd1);
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("halt_cleared", 32'(halt), 32'd0);
        chk("halt_reset_pc", pc, RST_PC);
        exp_pc = RST_PC;
`else
        chk("halt_tied_low", 32'(halt), 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(0, 2);
            v.inst    = $urandom;
            v.ren     = (kind == 1);
            v.wen     = (kind == 2);
            v.wmask   = sizes[$urandom_range(0, 2)];
            r         = $urandom;
`ifdef YSYX_23060111_MISALIGN_TRAP_EN
            r         = r & ~(v.wmask - 32'd1);
`endif
            v.raddr   = r;
            v.waddr   = r;
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.alu_wen = 1'($urandom_range(0, 1));
            r         = $urandom;
            v.dnpc    = r & ~32'd3;
            v.fdly    = $urandom_range(0, 2);
            v.rdly    = (kind == 0) ? 0 : int'($urandom_range(0, 3));
            v         = model(v);
            run_vec(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
